// File: rtl/cue_decode.sv
`default_nettype none
// ============================================================================
// Module   : cue_decode
// Brief    : Per-frame snapshot of three tracker zones, validated and reduced
//            to debounced front (smallest) / back (largest) box centres.
// Revision : 1.0 - initial release
// ============================================================================
module cue_decode #(
  parameter int MIN_SIZE    = 2,
  parameter int MISS_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [21:0] hor1,
  input  logic [21:0] vert1,
  input  logic [21:0] hor2,
  input  logic [21:0] vert2,
  input  logic [21:0] hor3,
  input  logic [21:0] vert3,
  output logic [10:0] front_x,
  output logic [10:0] front_y,
  output logic [10:0] back_x,
  output logic [10:0] back_y,
  output logic        cue_valid,
  output logic        cue_update,
  output logic [1:0]  zones_seen
);

  localparam int             c_MW        = (MISS_FRAMES < 2) ? 1 : $clog2(MISS_FRAMES + 1);
  localparam logic [c_MW-1:0] c_MISS_MAX = c_MW'(MISS_FRAMES);
  localparam logic [10:0]    c_MIN_SIZE  = 11'(MIN_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VALID = 3'd1,
    S_AREA  = 3'd2,
    S_CMP1  = 3'd3,
    S_CMP2  = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [21:0] w_hor  [3];
  logic [21:0] w_vert [3];
  logic        w_strobe;

  logic [10:0] r_left  [3];
  logic [10:0] r_right [3];
  logic [10:0] r_top   [3];
  logic [10:0] r_bot   [3];

  logic [10:0] w_w    [3];
  logic [10:0] w_h    [3];
  logic [2:0]  w_ok;
  logic [21:0] w_area [3];

  logic [10:0] r_w [3];
  logic [10:0] r_h [3];
  logic [2:0]  r_ok;
  logic [21:0] r_amin [3];
  logic [21:0] r_amax [3];

  logic [1:0]  r_fidx;
  logic [1:0]  r_bidx;
  logic [21:0] r_fbest;
  logic [21:0] r_bbest;

  logic [1:0]      w_cnt;
  logic [c_MW-1:0] r_miss;
  logic [c_MW-1:0] w_miss_inc;

  logic [10:0] w_fx, w_fy, w_bx, w_by;
  logic [10:0] r_fx, r_fy, r_bx, r_by;
  logic        r_valid;
  logic        r_update;
  logic [1:0]  r_zones;

  function automatic logic [10:0] mid(input logic [10:0] a, input logic [10:0] b);
    return 11'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  assign w_hor[0]  = hor1;
  assign w_hor[1]  = hor2;
  assign w_hor[2]  = hor3;
  assign w_vert[0] = vert1;
  assign w_vert[1] = vert2;
  assign w_vert[2] = vert3;

  assign w_strobe = (hcount == 11'd0) && (vcount == 11'd0);

  // Differences wrap at 11 bits; the ordering terms reject the wrapped cases.
  for (genvar gi = 0; gi < 3; gi++) begin : g_zone
    assign w_w[gi]    = r_right[gi] - r_left[gi];
    assign w_h[gi]    = r_bot[gi] - r_top[gi];
    assign w_ok[gi]   = (r_right[gi] > r_left[gi]) && (r_bot[gi] > r_top[gi]) &&
                        (w_w[gi] >= c_MIN_SIZE) && (w_h[gi] >= c_MIN_SIZE);
    assign w_area[gi] = {11'd0, r_w[gi]} * {11'd0, r_h[gi]};
  end

  assign w_cnt      = {1'b0, r_ok[0]} + {1'b0, r_ok[1]} + {1'b0, r_ok[2]};
  assign w_miss_inc = (r_miss == c_MISS_MAX) ? r_miss : r_miss + 1'b1;

  assign w_fx = mid(r_left[r_fidx], r_right[r_fidx]);
  assign w_fy = mid(r_top[r_fidx],  r_bot[r_fidx]);
  assign w_bx = mid(r_left[r_bidx], r_right[r_bidx]);
  assign w_by = mid(r_top[r_bidx],  r_bot[r_bidx]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_strobe) w_state_nxt = S_VALID;
      S_VALID: w_state_nxt = S_AREA;
      S_AREA:  w_state_nxt = S_CMP1;
      S_CMP1:  w_state_nxt = S_CMP2;
      S_CMP2:  w_state_nxt = S_OUT;
      S_OUT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_left[i]  <= '0;
        r_right[i] <= '0;
        r_top[i]   <= '0;
        r_bot[i]   <= '0;
        r_w[i]     <= '0;
        r_h[i]     <= '0;
        r_amin[i]  <= '0;
        r_amax[i]  <= '0;
      end
      r_ok     <= '0;
      r_fidx   <= '0;
      r_bidx   <= '0;
      r_fbest  <= '0;
      r_bbest  <= '0;
      r_miss   <= '0;
      r_fx     <= '0;
      r_fy     <= '0;
      r_bx     <= '0;
      r_by     <= '0;
      r_valid  <= 1'b0;
      r_update <= 1'b0;
      r_zones  <= '0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            for (int i = 0; i < 3; i++) begin
              r_left[i]  <= w_hor[i][21:11];
              r_right[i] <= w_hor[i][10:0];
              r_top[i]   <= w_vert[i][21:11];
              r_bot[i]   <= w_vert[i][10:0];
            end
          end
        end
        S_VALID: begin
          r_ok <= w_ok;
          for (int i = 0; i < 3; i++) begin
            r_w[i] <= w_w[i];
            r_h[i] <= w_h[i];
          end
        end
        S_AREA: begin
          // Invalid zones can never win either search: real areas are < 2^22-1.
          for (int i = 0; i < 3; i++) begin
            r_amin[i] <= r_ok[i] ? w_area[i] : '1;
            r_amax[i] <= r_ok[i] ? w_area[i] : '0;
          end
        end
        S_CMP1: begin
          if (r_amin[1] < r_amin[0]) begin
            r_fidx  <= 2'd1;
            r_fbest <= r_amin[1];
          end else begin
            r_fidx  <= 2'd0;
            r_fbest <= r_amin[0];
          end
          if (r_amax[1] >= r_amax[0]) begin
            r_bidx  <= 2'd1;
            r_bbest <= r_amax[1];
          end else begin
            r_bidx  <= 2'd0;
            r_bbest <= r_amax[0];
          end
        end
        S_CMP2: begin
          if (r_amin[2] < r_fbest) r_fidx <= 2'd2;
          if (r_amax[2] >= r_bbest) r_bidx <= 2'd2;
        end
        S_OUT: begin
          r_update <= 1'b1;
          r_zones  <= w_cnt;
          if (w_cnt >= 2'd2) begin
            r_fx    <= w_fx;
            r_fy    <= w_fy;
            r_bx    <= w_bx;
            r_by    <= w_by;
            r_miss  <= '0;
            r_valid <= 1'b1;
          end else begin
            r_miss <= w_miss_inc;
            if (w_miss_inc == c_MISS_MAX) r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign front_x    = r_fx;
  assign front_y    = r_fy;
  assign back_x     = r_bx;
  assign back_y     = r_by;
  assign cue_valid  = r_valid;
  assign cue_update = r_update;
  assign zones_seen = r_zones;

endmodule
`default_nettype wire
